// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter with Q-format input scaling and a 2-entry sample FIFO.
// Define I2S_TX_SAT_EN to clamp out-of-range samples; otherwise the low bits wrap.
module i2s_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_WIDTH   = DATA_WIDTH + 16,
  parameter int FRAC_SHIFT = 15,
  parameter int CLK_DIV    = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                en,
  input  logic [IN_WIDTH-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                underflow
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // ---------------------------------------------------------------------------
  // Input conversion
  // ---------------------------------------------------------------------------
  logic signed [IN_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0]      w_conv;

  assign w_shifted = $signed(s_data) >>> FRAC_SHIFT;

`ifdef I2S_TX_SAT_EN
  logic w_pos_ovf;
  logic w_neg_ovf;

  // Out of range when the bits above the DATA_WIDTH sign bit disagree with it.
  assign w_pos_ovf = ~w_shifted[IN_WIDTH-1] & (|w_shifted[IN_WIDTH-2:DATA_WIDTH-1]);
  assign w_neg_ovf =  w_shifted[IN_WIDTH-1] & ~(&w_shifted[IN_WIDTH-2:DATA_WIDTH-1]);

  always_comb begin
    w_conv = w_shifted[DATA_WIDTH-1:0];
    if (w_pos_ovf) begin
      w_conv = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (w_neg_ovf) begin
      w_conv = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end
`else
  logic w_unused_hi;

  assign w_unused_hi = ^w_shifted[IN_WIDTH-1:DATA_WIDTH];
  assign w_conv      = w_shifted[DATA_WIDTH-1:0];
`endif

  // ---------------------------------------------------------------------------
  // Sample FIFO (2 entries)
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [0:1];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_empty;

  assign w_head       = r_mem[r_rd_ptr];
  assign w_fifo_empty = (r_count == 2'd0);
  assign s_ready      = (r_count != 2'd2);
  assign w_push       = s_valid & s_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_conv;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Framing state machine
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic [DIV_W-1:0]      r_div;
  logic [BIT_W-1:0]      r_bitcnt;
  logic [DATA_WIDTH-2:0] r_shift;
  logic                  r_bclk;
  logic                  r_lrclk;
  logic                  r_sdata;
  logic                  r_underflow;
  logic                  r_first;
  logic                  r_stop;

  logic                  w_tc;
  logic                  w_fevent;
  logic [BIT_W-1:0]      w_bit_next;
  logic                  w_slot_start;
  logic                  w_stop;
  logic                  w_halt;

  assign w_tc         = (r_state == S_RUN) && (r_div == DIV_LAST);
  // The very first terminal count in RUN acts as a falling event even though bclk is low.
  assign w_fevent     = w_tc && (r_bclk || r_first);
  assign w_bit_next   = (r_first || (r_bitcnt == BIT_LAST)) ? '0 : r_bitcnt + 1'b1;
  assign w_slot_start = (w_bit_next == '0);
  assign w_stop       = r_stop || !en;
  assign w_halt       = w_fevent && w_slot_start && !r_lrclk && w_stop;
  assign w_pop        = w_fevent && w_slot_start && !w_halt && !w_fifo_empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_bclk      <= 1'b0;
      r_lrclk     <= 1'b0;
      r_sdata     <= 1'b0;
      r_underflow <= 1'b0;
      r_first     <= 1'b1;
      r_stop      <= 1'b0;
    end else begin
      r_underflow <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_div    <= '0;
          r_bitcnt <= '0;
          r_bclk   <= 1'b0;
          r_lrclk  <= 1'b0;
          r_sdata  <= 1'b0;
          r_first  <= 1'b1;
          r_stop   <= 1'b0;
          if (en && !w_fifo_empty) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!en) begin
            r_stop <= 1'b1;
          end
          if (!w_tc) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (!w_fevent) begin
              r_bclk <= 1'b1;
            end else if (w_halt) begin
              r_state  <= S_IDLE;
              r_bclk   <= 1'b0;
              r_lrclk  <= 1'b0;
              r_sdata  <= 1'b0;
              r_bitcnt <= '0;
              r_shift  <= '0;
            end else begin
              r_first  <= 1'b0;
              r_bclk   <= 1'b0;
              r_bitcnt <= w_bit_next;
              if (w_slot_start) begin
                if (w_fifo_empty) begin
                  r_shift     <= '0;
                  r_sdata     <= 1'b0;
                  r_underflow <= 1'b1;
                end else begin
                  r_shift <= w_head[DATA_WIDTH-2:0];
                  r_sdata <= w_head[DATA_WIDTH-1];
                end
              end else begin
                r_sdata <= r_shift[DATA_WIDTH-2];
                r_shift <= {r_shift[DATA_WIDTH-3:0], 1'b0};
              end
              // Word select flips while the last bit is on the wire, one bclk ahead of the MSB.
              if (w_bit_next == BIT_LAST) begin
                r_lrclk <= ~r_lrclk;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bclk      = r_bclk;
  assign lrclk     = r_lrclk;
  assign sdata     = r_sdata;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed checks of i2s_tx framing, conversion, FIFO and en/reset behaviour.
module tb_i2s_tx;

  logic        clk;
  logic        resetn;
  logic        en;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underflow;

  int n_cmp;
  int n_err;
  int n_timeout;
  int uf_cnt;
  int cyc;

  i2s_tx #(
    .DATA_WIDTH(16),
    .IN_WIDTH  (32),
    .FRAC_SHIFT(15),
    .CLK_DIV   (2)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (underflow === 1'b1) uf_cnt <= uf_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    en      = 1'b0;
    s_valid = 1'b0;
    resetn  = 1'b0;
    repeat (3) @(negedge clk);
    resetn  = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] d);
    int t;
    t = 0;
    while (s_ready !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) n_timeout++;
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_bclk(input logic lvl, output bit ok);
    int t;
    t = 0;
    while (bclk !== lvl && t < 64) begin
      @(negedge clk);
      t++;
    end
    ok = (bclk === lvl);
  endtask

  // Receiver view: sample sdata at each bclk rising edge, MSB first.
  task automatic rx_word(input int drop_at, output logic [15:0] w, output logic lr,
                         output int period);
    bit ok;
    int c0;
    w = '0; lr = 1'b0; period = 0; c0 = 0;
    for (int i = 0; i < 16; i++) begin
      wait_bclk(1'b0, ok);
      if (!ok) n_timeout++;
      wait_bclk(1'b1, ok);
      if (!ok) n_timeout++;
      w = {w[14:0], sdata};
      if (i == 0) begin
        lr = lrclk;
        c0 = cyc;
      end
      if (i == 1) period = cyc - c0;
      if (i == drop_at) en = 1'b0;
    end
  endtask

  task automatic idle_check(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen = seen | bclk | lrclk | sdata;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  logic [15:0] w;
  logic        lr;
  int          per;
  int          uf_base;
  int          acc;
  int          idx;
  int          n;
  logic        rdy;
  logic [31:0] vals [0:2];

  initial begin
    n_cmp = 0; n_err = 0; n_timeout = 0; uf_cnt = 0; cyc = 0;
    s_data = '0;

    // Reset values
    do_reset();
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_bclk",  {31'd0, bclk},      32'd0);
    chk("rst_lrclk", {31'd0, lrclk},     32'd0);
    chk("rst_sdata", {31'd0, sdata},     32'd0);
    chk("rst_uf",    {31'd0, underflow}, 32'd0);
    chk("rst_ready", {31'd0, s_ready},   32'd1);
    resetn = 1'b1;
    @(negedge clk);

    // Basic frame
    uf_base = uf_cnt;
    en = 1'b1;
    push(32'h12348000);
    push(32'hFFFF8000);
    rx_word(-1, w, lr, per);
    chk("A_left",     {16'd0, w},  32'h2469);
    chk("A_left_lr",  {31'd0, lr}, 32'd0);
    chk("A_period",   per,         32'd4);
    rx_word(15, w, lr, per);
    chk("A_right",    {16'd0, w},  32'hFFFF);
    chk("A_right_lr", {31'd0, lr}, 32'd1);
    idle_check("A_idle");
    chk("A_uf", uf_cnt - uf_base, 32'd0);

    // Out-of-range conversion
    do_reset();
    en = 1'b1;
    push(32'h40000000);
    push(32'hBFFF0000);
    rx_word(-1, w, lr, per);
`ifdef I2S_TX_SAT_EN
    chk("B_left",  {16'd0, w}, 32'h7FFF);
`else
    chk("B_left",  {16'd0, w}, 32'h8000);
`endif
    rx_word(15, w, lr, per);
`ifdef I2S_TX_SAT_EN
    chk("B_right", {16'd0, w}, 32'h8000);
`else
    chk("B_right", {16'd0, w}, 32'h7FFE);
`endif
    idle_check("B_idle");

    // Single sample: right slot underflows
    do_reset();
    uf_base = uf_cnt;
    en = 1'b1;
    push(32'hFFFE0000);
    rx_word(-1, w, lr, per);
    chk("C_left",    {16'd0, w}, 32'hFFFC);
    chk("C_uf_left", uf_cnt - uf_base, 32'd0);
    rx_word(15, w, lr, per);
    chk("C_right",   {16'd0, w}, 32'h0000);
    chk("C_right_lr", {31'd0, lr}, 32'd1);
    idle_check("C_idle");
    chk("C_uf_total", uf_cnt - uf_base, 32'd1);

    // Back-pressure while idle
    do_reset();
    vals[0] = 32'h00008000;
    vals[1] = 32'hFFFF0000;
    vals[2] = 32'h00010000;
    acc = 0; idx = 0;
    s_data = vals[0];
    s_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rdy = s_ready;
      @(negedge clk);
      if (rdy) begin
        acc++;
        idx++;
        s_data = vals[idx];
      end
    end
    s_valid = 1'b0;
    chk("D_accepted", acc, 32'd2);
    chk("D_ready_full", {31'd0, s_ready}, 32'd0);
    repeat (10) @(negedge clk);
    chk("D_ready_hold", {31'd0, s_ready}, 32'd0);
    chk("D_idle_bclk",  {31'd0, bclk},    32'd0);
    en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (s_ready !== 1'b1 && n < 50);
    chk("D_first_pop", n, 32'd3);
    rx_word(-1, w, lr, per);
    chk("D_left",  {16'd0, w}, 32'h0001);
    rx_word(15, w, lr, per);
    chk("D_right", {16'd0, w}, 32'hFFFE);
    idle_check("D_idle");

    // en dropped during the left slot
    do_reset();
    en = 1'b1;
    push(32'h00050000);
    push(32'hFFFD8000);
    rx_word(3, w, lr, per);
    chk("E_left",     {16'd0, w},  32'h000A);
    rx_word(-1, w, lr, per);
    chk("E_right",    {16'd0, w},  32'hFFFB);
    chk("E_right_lr", {31'd0, lr}, 32'd1);
    idle_check("E_idle");

    // Reset in the middle of a slot
    do_reset();
    en = 1'b1;
    push(32'h12348000);
    push(32'hFFFF8000);
    n = 0;
    while (lrclk !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) n_timeout++;
    push(32'h00010000);
    begin
      bit ok;
      wait_bclk(1'b1, ok);
      if (!ok) n_timeout++;
    end
    chk("F_pre_bclk",  {31'd0, bclk},  32'd1);
    chk("F_pre_lrclk", {31'd0, lrclk}, 32'd1);
    chk("F_pre_sdata", {31'd0, sdata}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("F_bclk",  {31'd0, bclk},      32'd0);
    chk("F_lrclk", {31'd0, lrclk},     32'd0);
    chk("F_sdata", {31'd0, sdata},     32'd0);
    chk("F_uf",    {31'd0, underflow}, 32'd0);
    chk("F_ready", {31'd0, s_ready},   32'd1);
    resetn = 1'b1;
    idle_check("F_post_idle");
    en = 1'b0;

    chk("timeouts", n_timeout, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
